// File: rtl/sha_schedule.sv
// sha_schedule: SHA-256 / SHA-512 message-schedule expander.
// Keeps a 16-word sliding window and emits W[0..Nr-1] one word per accepted cycle.
// Optional macro SHA_SCHEDULE_PREFETCH_EN: a new block may be captured on the last
// round of the current block, giving back-to-back blocks with no idle bubble.
module sha_schedule #(
  parameter int Nw = 32,
  parameter int Nm = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [16*Nw-1:0] Block_Data,
  input  logic [Nm-1:0]    Block_Index,
  input  logic             Block_Valid,
  output logic             Block_Ready,
  output logic [Nw-1:0]    W_Data,
  output logic [6:0]       W_Round,
  output logic [Nm-1:0]    W_Index,
  output logic             W_Valid,
  output logic             W_Last,
  input  logic             W_Ready
);

  localparam int Nr = (Nw == 64) ? 80 : 64;
  localparam logic [6:0] LastRound = 7'(Nr - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [Nw-1:0] window [16];
  logic [6:0]    round_q;
  logic [Nm-1:0] index_q;

  logic          at_last;
  logic          accept;
  logic          capture;
  logic [Nw-1:0] next_word;

  function automatic logic [Nw-1:0] rotr(input logic [Nw-1:0] x, input int n);
    return (x >> n) | (x << (Nw - n));
  endfunction

  function automatic logic [Nw-1:0] small_sigma0(input logic [Nw-1:0] x);
    if (Nw == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else          return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [Nw-1:0] small_sigma1(input logic [Nw-1:0] x);
    if (Nw == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else          return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // The window slot 16 positions ahead of window[0] is built from taps 0, 1, 9 and 14.
  assign next_word = small_sigma1(window[14]) + window[9] + small_sigma0(window[1]) + window[0];

  assign at_last = (round_q == LastRound);
  assign accept  = (state == RUN) && W_Ready;

`ifdef SHA_SCHEDULE_PREFETCH_EN
  assign Block_Ready = (state == IDLE) || ((state == RUN) && at_last && W_Ready);
`else
  assign Block_Ready = (state == IDLE);
`endif

  assign capture = Block_Valid && Block_Ready;

  assign W_Valid = (state == RUN);
  assign W_Data  = window[0];
  assign W_Round = round_q;
  assign W_Index = index_q;
  assign W_Last  = (state == RUN) && at_last;

  // Block capture has priority over the last-round accept so a prefetched block replaces the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      round_q <= '0;
      index_q <= '0;
      for (int k = 0; k < 16; k++) window[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < 16; k++) window[k] <= Block_Data[k*Nw +: Nw];
      index_q <= Block_Index;
      round_q <= '0;
      state   <= RUN;
    end else if (accept) begin
      for (int k = 0; k < 15; k++) window[k] <= window[k+1];
      window[15] <= next_word;
      if (at_last) begin
        state   <= IDLE;
        round_q <= '0;
      end else begin
        round_q <= round_q + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha_schedule.sv
// tb_sha_schedule: checks sha_schedule (SHA-256 and SHA-512 instances) against a
// full-array schedule model computed from the SHA recurrence.
module tb_sha_schedule;

  logic clk = 1'b0;
  logic rst;

  logic [511:0] block_data32;
  logic [63:0]  block_index32;
  logic         block_valid32;
  logic         block_ready32;
  logic [31:0]  w_data32;
  logic [6:0]   w_round32;
  logic [63:0]  w_index32;
  logic         w_valid32;
  logic         w_last32;
  logic         w_ready32;

  logic [1023:0] block_data64;
  logic [63:0]   block_index64;
  logic          block_valid64;
  logic          block_ready64;
  logic [63:0]   w_data64;
  logic [6:0]    w_round64;
  logic [63:0]   w_index64;
  logic          w_valid64;
  logic          w_last64;
  logic          w_ready64;

  int assertions = 0;
  int failures   = 0;

  logic [63:0] model_blk [16];
  logic [63:0] model_w   [80];
  logic [63:0] exp_word  [160];
  logic [63:0] exp_idx   [160];
  logic [63:0] got_word  [160];

  int cycles;
  int cnt64;
  int cyc64;
  logic [63:0] got64_16;

  sha_schedule #(.Nw(32), .Nm(64)) dut32 (
    .clk(clk), .rst(rst),
    .Block_Data(block_data32), .Block_Index(block_index32),
    .Block_Valid(block_valid32), .Block_Ready(block_ready32),
    .W_Data(w_data32), .W_Round(w_round32), .W_Index(w_index32),
    .W_Valid(w_valid32), .W_Last(w_last32), .W_Ready(w_ready32)
  );

  sha_schedule #(.Nw(64), .Nm(64)) dut64 (
    .clk(clk), .rst(rst),
    .Block_Data(block_data64), .Block_Index(block_index64),
    .Block_Valid(block_valid64), .Block_Ready(block_ready64),
    .W_Data(w_data64), .W_Round(w_round64), .W_Index(w_index64),
    .W_Valid(w_valid64), .W_Last(w_last64), .W_Ready(w_ready64)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int nw);
    logic [63:0] mask = (nw == 64) ? ~64'd0 : 64'hFFFF_FFFF;
    return ((x >> n) | (x << (nw - n))) & mask;
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x, input int nw);
    if (nw == 64) return rotr(x, 1, nw) ^ rotr(x, 8, nw) ^ (x >> 7);
    return rotr(x, 7, nw) ^ rotr(x, 18, nw) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x, input int nw);
    if (nw == 64) return rotr(x, 19, nw) ^ rotr(x, 61, nw) ^ (x >> 6);
    return rotr(x, 17, nw) ^ rotr(x, 19, nw) ^ (x >> 10);
  endfunction

  // Whole-schedule reference: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
  task automatic buildModel(input int nw);
    int nr = (nw == 64) ? 80 : 64;
    logic [63:0] mask = (nw == 64) ? ~64'd0 : 64'hFFFF_FFFF;
    for (int t = 0; t < 16; t++) model_w[t] = model_blk[t] & mask;
    for (int t = 16; t < nr; t++)
      model_w[t] = (ssig1(model_w[t-2], nw) + model_w[t-7] + ssig0(model_w[t-15], nw) + model_w[t-16]) & mask;
  endtask

  task automatic loadExpect32(input logic [63:0] idx, input int base);
    buildModel(32);
    for (int t = 0; t < 64; t++) begin
      exp_word[base+t] = model_w[t];
      exp_idx[base+t]  = idx;
    end
    for (int i = 0; i < 16; i++) block_data32[i*32 +: 32] = model_blk[i][31:0];
    block_index32 = idx;
  endtask

  task automatic abcBlock32();
    for (int i = 0; i < 16; i++) model_blk[i] = 64'd0;
    model_blk[0]  = 64'h6162_6380;
    model_blk[15] = 64'h0000_0018;
  endtask

  task automatic randomBlock();
    for (int i = 0; i < 16; i++) model_blk[i] = {32'd0, $urandom()};
  endtask

  // Offers the prepared block for one cycle from IDLE; first word is valid on return.
  task automatic applyStimulus();
    block_valid32 = 1'b1;
    #1;
    checkOutput("block_ready_capture", 64'(block_ready32), 64'd1);
    @(posedge clk); #1;
    block_valid32 = 1'b0;
  endtask

  // Consumes n_words from dut32, comparing every valid cycle with exp_word/exp_idx.
  task automatic runAndCheck(input int n_words, input int nr, input bit random_ready,
                             input int max_cycles, output int used);
    int  cnt = 0;
    bit  accepted;
    bit  captured;
    used = 0;
    while (cnt < n_words && used < max_cycles) begin
      w_ready32 = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (w_valid32) begin
        checkOutput("w_data",  64'(w_data32),  exp_word[cnt]);
        checkOutput("w_round", 64'(w_round32), 64'(cnt % nr));
        checkOutput("w_index", w_index32,      exp_idx[cnt]);
        checkOutput("w_last",  64'(w_last32),  64'((cnt % nr) == nr - 1));
`ifdef SHA_SCHEDULE_PREFETCH_EN
        checkOutput("block_ready_run", 64'(block_ready32), 64'(((cnt % nr) == nr - 1) && w_ready32));
`else
        checkOutput("block_ready_run", 64'(block_ready32), 64'd0);
`endif
        got_word[cnt] = 64'(w_data32);
      end else begin
        checkOutput("block_ready_idle", 64'(block_ready32), 64'd1);
        checkOutput("w_last_idle",      64'(w_last32),      64'd0);
      end
      accepted = w_valid32 && w_ready32;
      captured = block_valid32 && block_ready32;
      @(posedge clk); #1;
      if (captured) block_valid32 = 1'b0;
      if (accepted) cnt++;
      used++;
    end
    w_ready32 = 1'b1;
    checkOutput("word_count", 64'(cnt), 64'(n_words));
  endtask

  initial begin
    // Reset with a block offered: it must not be captured.
    rst = 1'b1;
    w_ready32 = 1'b1; w_ready64 = 1'b1;
    block_valid64 = 1'b0; block_data64 = '0; block_index64 = '0;
    abcBlock32();
    loadExpect32(64'd3, 0);
    block_valid32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_w_valid",     64'(w_valid32),     64'd0);
    checkOutput("rst_w_last",      64'(w_last32),      64'd0);
    checkOutput("rst_w_data",      64'(w_data32),      64'd0);
    checkOutput("rst_w_round",     64'(w_round32),     64'd0);
    checkOutput("rst_w_index",     w_index32,          64'd0);
    checkOutput("rst_block_ready", 64'(block_ready32), 64'd1);
    checkOutput("rst_w_valid64",   64'(w_valid64),     64'd0);
    rst = 1'b0;
    block_valid32 = 1'b0;
    @(posedge clk); #1;
    checkOutput("no_capture_in_rst", 64'(w_valid32), 64'd0);

    // SHA-256 "abc" with W_Ready held high.
    $display("[TB] abc block, W_Ready high");
    abcBlock32();
    loadExpect32(64'd1, 0);
    applyStimulus();
    runAndCheck(64, 64, 1'b0, 200, cycles);
    checkOutput("abc_cycles",       64'(cycles),        64'd64);
    checkOutput("abc_w16",          got_word[16],       64'h6162_6380);
    checkOutput("abc_w17",          got_word[17],       64'h000F_0000);
    checkOutput("abc_w63",          got_word[63],       64'h12B1_EDEB);
    checkOutput("abc_done_valid",   64'(w_valid32),     64'd0);
    checkOutput("abc_done_ready",   64'(block_ready32), 64'd1);

    // Same block with random back-pressure.
    $display("[TB] abc block, random W_Ready");
    abcBlock32();
    loadExpect32(64'd2, 0);
    applyStimulus();
    runAndCheck(64, 64, 1'b1, 1000, cycles);
    checkOutput("stall_done_valid", 64'(w_valid32), 64'd0);

    // Two blocks back-to-back; block 6 is held valid throughout block 5's run.
    $display("[TB] back-to-back blocks");
    randomBlock();
    loadExpect32(64'd5, 0);
    applyStimulus();
    block_valid32 = 1'b1;
    randomBlock();
    loadExpect32(64'd6, 64);
    runAndCheck(128, 64, 1'b0, 400, cycles);
`ifdef SHA_SCHEDULE_PREFETCH_EN
    checkOutput("b2b_cycles", 64'(cycles), 64'd128);
`else
    checkOutput("b2b_cycles", 64'(cycles), 64'd129);
`endif
    checkOutput("b2b_done_valid", 64'(w_valid32), 64'd0);

    // Reset in the middle of a block at round 20 with a new block already offered.
    $display("[TB] reset at round 20");
    randomBlock();
    loadExpect32(64'd9, 0);
    applyStimulus();
    runAndCheck(20, 64, 1'b0, 100, cycles);
    checkOutput("round_before_rst", 64'(w_round32), 64'd20);
    randomBlock();
    loadExpect32(64'd7, 0);
    block_valid32 = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_w_valid",     64'(w_valid32),     64'd0);
    checkOutput("midrst_w_last",      64'(w_last32),      64'd0);
    checkOutput("midrst_w_round",     64'(w_round32),     64'd0);
    checkOutput("midrst_w_index",     w_index32,          64'd0);
    checkOutput("midrst_w_data",      64'(w_data32),      64'd0);
    checkOutput("midrst_block_ready", 64'(block_ready32), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    block_valid32 = 1'b0;
    runAndCheck(64, 64, 1'b0, 200, cycles);

    // SHA-512 "abc" block on the 64-bit instance with random back-pressure.
    $display("[TB] SHA-512 abc block");
    for (int i = 0; i < 16; i++) model_blk[i] = 64'd0;
    model_blk[0]  = 64'h6162_6380_0000_0000;
    model_blk[15] = 64'h0000_0000_0000_0018;
    buildModel(64);
    for (int i = 0; i < 16; i++) block_data64[i*64 +: 64] = model_blk[i];
    block_index64 = 64'd42;
    block_valid64 = 1'b1;
    #1;
    checkOutput("b64_block_ready", 64'(block_ready64), 64'd1);
    @(posedge clk); #1;
    block_valid64 = 1'b0;
    cnt64 = 0;
    cyc64 = 0;
    got64_16 = '0;
    while (cnt64 < 80 && cyc64 < 1000) begin
      w_ready64 = 1'($urandom_range(0, 1));
      #1;
      checkOutput("b64_w_valid", 64'(w_valid64), 64'd1);
      checkOutput("b64_w_data",  w_data64,       model_w[cnt64]);
      checkOutput("b64_w_round", 64'(w_round64), 64'(cnt64));
      checkOutput("b64_w_index", w_index64,      64'd42);
      checkOutput("b64_w_last",  64'(w_last64),  64'(cnt64 == 79));
      if (cnt64 == 16) got64_16 = w_data64;
      @(posedge clk); #1;
      if (w_ready64) cnt64++;
      cyc64++;
    end
    w_ready64 = 1'b1;
    checkOutput("b64_word_count", 64'(cnt64),      64'd80);
    checkOutput("b64_w16",        got64_16,        64'h6162_6380_0000_0000);
    checkOutput("b64_done_valid", 64'(w_valid64),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/sha_schedule.md
# sha_schedule

Message-schedule expander for the SHA hash datapath. It accepts one 16-word padded message block from the block formatter and emits the expanded schedule words W[0..Nr-1] one per accepted cycle to the compression rounds. It keeps only a 16-word sliding window, so storage is 16 x Nw bits rather than Nr x Nw.

## Interface
- Nw, 32, word width; 32 selects SHA-256 (Nr=64), 64 selects SHA-512 (Nr=80); other values illegal
- Nm, 64, width of the block index carried alongside the block
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- Block_Data  in  16*Nw  padded block; word i at bits [i*Nw +: Nw], word 0 = W[0]
- Block_Index  in  Nm  block sequence number, captured with the block
- Block_Valid  in  1  block offered this cycle
- Block_Ready  out  1  block can be captured this cycle
- W_Data  out  Nw  current schedule word W[t]
- W_Round  out  7  current round number t
- W_Index  out  Nm  index of the block being expanded
- W_Valid  out  1  W_Data/W_Round valid
- W_Last  out  1  high with W_Valid when t = Nr-1
- W_Ready  in  1  consumer takes W[t] this cycle

## Operation
- States: IDLE, RUN. Reset forces IDLE, t=0, window and W_Index cleared.
- IDLE: Block_Ready=1, W_Valid=0. Block_Valid=1 -> window[k]=word k (k=0..15), W_Index<=Block_Index, t<=0, -> RUN.
- RUN: Block_Ready=0 (see Configuration), W_Valid=1, W_Data=window[0], W_Round=t.
- Accept = W_Valid & W_Ready. On accept: window[k]<=window[k+1] for k=0..14; window[15]<=s1(window[14]) + window[9] + s0(window[1]) + window[0], modulo 2^Nw; t<=t+1.
- Accept with t=Nr-1 -> IDLE, t<=0. New-word computation on that cycle is don't-care.
- W_Ready=0 in RUN: all state held, outputs stable.
- Nw=32: s0(x)=ROTR7^ROTR18^SHR3, s1(x)=ROTR17^ROTR19^SHR10.
- Nw=64: s0(x)=ROTR1^ROTR8^SHR7, s1(x)=ROTR19^ROTR61^SHR6.
- Block_Valid while Block_Ready=0 is ignored; the formatter holds until Ready.

## Timing
- Reset values: W_Valid=0, W_Last=0, W_Data=0, W_Round=0, W_Index=0; Block_Ready=1. A Block_Valid during rst is not captured.
- Capture cycle -> W[0] valid next cycle (latency 1).
- With W_Ready held high: one word per cycle, W[Nr-1] on cycle Nr after capture, Block_Ready high the cycle after.
- Throughput without the macro: Nr+1 cycles per block (one IDLE bubble).
- rst mid-RUN: next cycle IDLE, window discarded, no further W_Valid until a new capture.
- W_Last is combinational from t and state; it is never high when W_Valid=0.

## Configuration
- SHA_SCHEDULE_PREFETCH_EN defined: Block_Ready is also 1 in RUN when t=Nr-1 and W_Ready=1. A Block_Valid then loads the new block and W_Index, t<=0, and the block stays in RUN. This gives back-to-back blocks with no bubble (Nr cycles per block).
- SHA_SCHEDULE_PREFETCH_EN not defined: Block_Ready=1 only in IDLE.

## Test plan
- Nw=32, block "abc" (W0=0x61626380, W1..W14=0, W15=0x00000018), W_Ready=1 -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB, W_Last only at W_Round=63, Block_Ready returns the next cycle.
- Same block, W_Ready toggled pseudo-randomly -> identical 64-word sequence; outputs stable on every stalled cycle.
- Two blocks (Block_Index 5 then 6) presented back-to-back -> W_Index 5 for 64 words, then 6. Gap is 1 cycle without the macro and 0 with SHA_SCHEDULE_PREFETCH_EN.
- Assert rst at t=20, Block_Valid held high during rst -> W_Valid=0 the next cycle. After rst drops, the block is captured and W_Round restarts at 0.
- Block_Valid pulsed during RUN with t<Nr-1 -> ignored; schedule for the current block is unchanged.
- Nw=64, SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18) -> 80 words, W_Last at 79, W16=0x6162638000000000.
